imm_instr_encoder: RTL and testbench

- Inverse of the decode-stage immediate extender.
- Takes an instruction format select, a 32-bit signed/shifted immediate value and register/opcode fields, and packs them into a 32-bit RV32I instruction word.
- Range-checks the immediate for the selected format.
- Two-stage valid/ready pipeline; feeds the test-program generator and the instruction-memory preload path.

---
 rtl/imm_instr_encoder.sv | 214 +++++++++++++++++++++
 tb/tb_imm_instr_encoder.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_instr_encoder.sv
// imm_instr_encoder: packs a format select, an extender-form immediate and the
// register/opcode fields into an RV32I instruction word, flagging immediates that
// cannot be represented. Two-stage valid/ready pipeline (input reg, output reg).
// Optional build macro IMM_ENC_ERR_COUNT_EN adds the ERR_COUNT output and counter.
module imm_instr_encoder #(
  parameter int unsigned                  DATA_WIDTH        = 32,
  parameter int unsigned                  IMM_FORMAT_SELECT = 3,
  parameter logic [IMM_FORMAT_SELECT-1:0] R_FORMAT          = 3'b000,
  parameter logic [IMM_FORMAT_SELECT-1:0] I_FORMAT          = 3'b001,
  parameter logic [IMM_FORMAT_SELECT-1:0] S_FORMAT          = 3'b010,
  parameter logic [IMM_FORMAT_SELECT-1:0] U_FORMAT          = 3'b011,
  parameter logic [IMM_FORMAT_SELECT-1:0] SB_FORMAT         = 3'b100,
  parameter logic [IMM_FORMAT_SELECT-1:0] UJ_FORMAT         = 3'b101,
  parameter int unsigned                  COUNT_WIDTH       = 16
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         IN_VALID,
  output logic                         IN_READY,
  input  logic [IMM_FORMAT_SELECT-1:0] IMM_FORMAT,
  input  logic [DATA_WIDTH-1:0]        IMM_VALUE,
  input  logic [6:0]                   OPCODE,
  input  logic [4:0]                   RD,
  input  logic [4:0]                   RS1,
  input  logic [4:0]                   RS2,
  input  logic [2:0]                   FUNCT3,
  input  logic [6:0]                   FUNCT7,
  output logic                         OUT_VALID,
  input  logic                         OUT_READY,
  output logic [DATA_WIDTH-1:0]        INSTRUCTION,
  output logic                         IMM_ERROR,
  output logic [COUNT_WIDTH-1:0]       ENC_COUNT
`ifdef IMM_ENC_ERR_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0]       ERR_COUNT
`endif
);

  // Stage A (input register)
  logic                         a_valid_q, a_valid_d;
  logic [IMM_FORMAT_SELECT-1:0] a_fmt_q, a_fmt_d;
  logic [DATA_WIDTH-1:0]        a_imm_q, a_imm_d;
  logic [6:0]                   a_opcode_q, a_opcode_d;
  logic [4:0]                   a_rd_q, a_rd_d;
  logic [4:0]                   a_rs1_q, a_rs1_d;
  logic [4:0]                   a_rs2_q, a_rs2_d;
  logic [2:0]                   a_funct3_q, a_funct3_d;
  logic [6:0]                   a_funct7_q, a_funct7_d;

  // Stage B (output register)
  logic                         out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]        instr_q, instr_d;
  logic                         err_q, err_d;
  logic [COUNT_WIDTH-1:0]       enc_count_q, enc_count_d;

  logic                         a_load, b_load, out_hs;
  logic [DATA_WIDTH-1:0]        enc_instr;
  logic                         enc_err;
  logic                         fits_12, fits_13, fits_21;

  // Handshake control: stage A may refill in the same cycle it hands off to B
  always_comb begin
    IN_READY = !a_valid_q || !out_valid_q || OUT_READY;
    a_load   = IN_VALID && IN_READY;
    b_load   = a_valid_q && (!out_valid_q || OUT_READY);
    out_hs   = out_valid_q && OUT_READY;
  end

  // Encoder: immediate range checks plus field packing of the stage A request
  always_comb begin
    enc_instr = '0;
    enc_err   = 1'b0;
    // Upper bits must all replicate the sign bit of the field width
    fits_12 = (&a_imm_q[31:11]) || !(|a_imm_q[31:11]);
    fits_13 = (&a_imm_q[31:12]) || !(|a_imm_q[31:12]);
    fits_21 = (&a_imm_q[31:20]) || !(|a_imm_q[31:20]);
    case (a_fmt_q)
      R_FORMAT: begin
        enc_instr = {a_funct7_q, a_rs2_q, a_rs1_q, a_funct3_q, a_rd_q, a_opcode_q};
      end
      I_FORMAT: begin
        enc_instr = {a_imm_q[11:0], a_rs1_q, a_funct3_q, a_rd_q, a_opcode_q};
        enc_err   = !fits_12;
      end
      S_FORMAT: begin
        enc_instr = {a_imm_q[11:5], a_rs2_q, a_rs1_q, a_funct3_q, a_imm_q[4:0], a_opcode_q};
        enc_err   = !fits_12;
      end
      U_FORMAT: begin
        enc_instr = {a_imm_q[31:12], a_rd_q, a_opcode_q};
        enc_err   = |a_imm_q[11:0];
      end
      SB_FORMAT: begin
        enc_instr = {a_imm_q[12], a_imm_q[10:5], a_rs2_q, a_rs1_q, a_funct3_q,
                     a_imm_q[4:1], a_imm_q[11], a_opcode_q};
        enc_err   = a_imm_q[0] || !fits_13;
      end
      UJ_FORMAT: begin
        enc_instr = {a_imm_q[20], a_imm_q[10:1], a_imm_q[11], a_imm_q[19:12],
                     a_rd_q, a_opcode_q};
        enc_err   = a_imm_q[0] || !fits_21;
      end
      default: begin
        enc_instr = '0;
        enc_err   = 1'b1;
      end
    endcase
  end

  // Next-state for both stages and the handshake counter
  always_comb begin
    a_valid_d  = a_valid_q;
    a_fmt_d    = a_fmt_q;
    a_imm_d    = a_imm_q;
    a_opcode_d = a_opcode_q;
    a_rd_d     = a_rd_q;
    a_rs1_d    = a_rs1_q;
    a_rs2_d    = a_rs2_q;
    a_funct3_d = a_funct3_q;
    a_funct7_d = a_funct7_q;
    out_valid_d = out_valid_q;
    instr_d     = instr_q;
    err_d       = err_q;
    enc_count_d = enc_count_q;

    if (a_load) begin
      a_valid_d  = 1'b1;
      a_fmt_d    = IMM_FORMAT;
      a_imm_d    = IMM_VALUE;
      a_opcode_d = OPCODE;
      a_rd_d     = RD;
      a_rs1_d    = RS1;
      a_rs2_d    = RS2;
      a_funct3_d = FUNCT3;
      a_funct7_d = FUNCT7;
    end else if (b_load) begin
      a_valid_d = 1'b0;
    end

    if (b_load) begin
      out_valid_d = 1'b1;
      instr_d     = enc_instr;
      err_d       = enc_err;
    end else if (OUT_READY) begin
      out_valid_d = 1'b0;
    end

    if (out_hs && (enc_count_q != '1)) begin
      enc_count_d = enc_count_q + COUNT_WIDTH'(1);
    end
  end

  // Pipeline state; reset discards anything in flight
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_valid_q   <= 1'b0;
      a_fmt_q     <= '0;
      a_imm_q     <= '0;
      a_opcode_q  <= '0;
      a_rd_q      <= '0;
      a_rs1_q     <= '0;
      a_rs2_q     <= '0;
      a_funct3_q  <= '0;
      a_funct7_q  <= '0;
      out_valid_q <= 1'b0;
      instr_q     <= '0;
      err_q       <= 1'b0;
      enc_count_q <= '0;
    end else begin
      a_valid_q   <= a_valid_d;
      a_fmt_q     <= a_fmt_d;
      a_imm_q     <= a_imm_d;
      a_opcode_q  <= a_opcode_d;
      a_rd_q      <= a_rd_d;
      a_rs1_q     <= a_rs1_d;
      a_rs2_q     <= a_rs2_d;
      a_funct3_q  <= a_funct3_d;
      a_funct7_q  <= a_funct7_d;
      out_valid_q <= out_valid_d;
      instr_q     <= instr_d;
      err_q       <= err_d;
      enc_count_q <= enc_count_d;
    end
  end

  assign OUT_VALID   = out_valid_q;
  assign INSTRUCTION = instr_q;
  assign IMM_ERROR   = err_q;
  assign ENC_COUNT   = enc_count_q;

`ifdef IMM_ENC_ERR_COUNT_EN
  logic [COUNT_WIDTH-1:0] err_count_q, err_count_d;

  // Count emitted words that carried an error, saturating
  always_comb begin
    err_count_d = err_count_q;
    if (out_hs && err_q && (err_count_q != '1)) begin
      err_count_d = err_count_q + COUNT_WIDTH'(1);
    end
  end

  // Error counter register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign ERR_COUNT = err_count_q;
`endif

endmodule

// File: tb/tb_imm_instr_encoder.sv
// Bench for imm_instr_encoder: directed vector table, latency, backpressure,
// asynchronous reset and randomized round trip through a reference extender.
// Honours IMM_ENC_ERR_COUNT_EN for the optional ERR_COUNT output.
module tb_imm_instr_encoder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [2:0]  IMM_FORMAT = '0;
  logic [31:0] IMM_VALUE = '0;
  logic [6:0]  OPCODE = '0;
  logic [4:0]  RD = '0, RS1 = '0, RS2 = '0;
  logic [2:0]  FUNCT3 = '0;
  logic [6:0]  FUNCT7 = '0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b1;
  logic [31:0] INSTRUCTION;
  logic        IMM_ERROR;
  logic [15:0] ENC_COUNT;
`ifdef IMM_ENC_ERR_COUNT_EN
  logic [15:0] ERR_COUNT;
`endif

  imm_instr_encoder dut (
    .CLK         (CLK),
    .RST         (RST),
    .IN_VALID    (IN_VALID),
    .IN_READY    (IN_READY),
    .IMM_FORMAT  (IMM_FORMAT),
    .IMM_VALUE   (IMM_VALUE),
    .OPCODE      (OPCODE),
    .RD          (RD),
    .RS1         (RS1),
    .RS2         (RS2),
    .FUNCT3      (FUNCT3),
    .FUNCT7      (FUNCT7),
    .OUT_VALID   (OUT_VALID),
    .OUT_READY   (OUT_READY),
    .INSTRUCTION (INSTRUCTION),
    .IMM_ERROR   (IMM_ERROR),
    .ENC_COUNT   (ENC_COUNT)
`ifdef IMM_ENC_ERR_COUNT_EN
    ,
    .ERR_COUNT   (ERR_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic [6:0]  op;
    logic [31:0] exp_instr;
    logic        exp_err;
    logic        rt;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vecs[12];
  int   checks = 0;
  int   errors = 0;
  int   accepted = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference decode-stage extender, used for the round trip
  function automatic logic [31:0] extend(input logic [2:0] fmt, input logic [31:0] i);
    case (fmt)
      3'b001:  return {{20{i[31]}}, i[31:20]};
      3'b010:  return {{20{i[31]}}, i[31:25], i[11:7]};
      3'b011:  return {i[31:12], 12'b0};
      3'b100:  return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'b101:  return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  function automatic vec_t mk(input logic [2:0] fmt, input logic [31:0] imm,
                              input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] ei, input logic ee);
    vec_t v;
    v.fmt = fmt; v.imm = imm; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.f3 = f3; v.f7 = f7; v.exp_instr = ei; v.exp_err = ee;
    return v;
  endfunction

  // Called at a falling edge; returns at the falling edge after the accepting rising edge
  task automatic send(input vec_t v, input logic rt);
    int   guard;
    logic acc;
    sb_t  e;
    IMM_FORMAT = v.fmt; IMM_VALUE = v.imm; OPCODE = v.op; RD = v.rd;
    RS1 = v.rs1; RS2 = v.rs2; FUNCT3 = v.f3; FUNCT7 = v.f7;
    IN_VALID = 1'b1;
    guard = 0;
    acc = 1'b0;
    while (!acc && guard < 200) begin
      #1;
      acc = IN_READY;
      if (acc) begin
        e.fmt = v.fmt; e.imm = v.imm; e.op = v.op;
        e.exp_instr = v.exp_instr; e.exp_err = v.exp_err; e.rt = rt;
        sb_q.push_back(e);
        accepted++;
      end
      @(negedge CLK);
      guard++;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input string name);
    int guard = 0;
    while (sb_q.size() != 0 && guard < 500) begin
      @(negedge CLK);
      guard++;
    end
    chk(name, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    IN_VALID = 1'b0;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    sb_q.delete();
  endtask

  // Output monitor: every output handshake is matched in order against the scoreboard
  always @(negedge CLK) begin
    #2;
    if (!RST && OUT_VALID && OUT_READY) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_output", INSTRUCTION, 32'h0);
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=valid required=no word");
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        if (e.rt) begin
          chk("roundtrip_imm", extend(e.fmt, INSTRUCTION), e.imm);
          chk("roundtrip_opcode", {25'd0, INSTRUCTION[6:0]}, {25'd0, e.op});
          chk("roundtrip_err", {31'd0, IMM_ERROR}, 32'd0);
        end else begin
          chk("word", INSTRUCTION, e.exp_instr);
          chk("word_err", {31'd0, IMM_ERROR}, {31'd0, e.exp_err});
        end
      end
    end
  end

  initial begin
    logic [31:0] held;
    vec_t        v;
    logic [31:0] r;
    int          seen;

    vecs[0]  = mk(3'b001, 32'hFFFF_FFFF, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFF1_0093, 1'b0);
    vecs[1]  = mk(3'b001, 32'h0000_0800, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'h8001_0093, 1'b1);
    vecs[2]  = mk(3'b100, 32'hFFFF_FFFC, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFE20_8EE3, 1'b0);
    vecs[3]  = mk(3'b100, 32'h0000_0002, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0020_8163, 1'b0);
    vecs[4]  = mk(3'b100, 32'h0000_0003, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0020_8163, 1'b1);
    vecs[5]  = mk(3'b101, 32'h0000_0800, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_00EF, 1'b0);
    vecs[6]  = mk(3'b011, 32'h1234_5000, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_52B7, 1'b0);
    vecs[7]  = mk(3'b011, 32'h1234_5001, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_52B7, 1'b1);
    vecs[8]  = mk(3'b111, 32'h0000_0010, 7'h33, 5'd3, 5'd4, 5'd5, 3'd1, 7'd1, 32'h0000_0000, 1'b1);
    vecs[9]  = mk(3'b000, 32'hDEAD_BEEF, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'h4031_00B3, 1'b0);
    vecs[10] = mk(3'b010, 32'hFFFF_FFF8, 7'h23, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, 32'hFE31_2C23, 1'b0);
    vecs[11] = mk(3'b010, 32'hFFFF_F000, 7'h23, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, 32'h0031_2023, 1'b1);

    // Reset state
    @(negedge CLK);
    chk("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
    chk("rst_instruction", INSTRUCTION, 32'd0);
    chk("rst_imm_error", {31'd0, IMM_ERROR}, 32'd0);
    chk("rst_enc_count", {16'd0, ENC_COUNT}, 32'd0);
    chk("rst_in_ready", {31'd0, IN_READY}, 32'd1);
    RST = 1'b0;
    @(negedge CLK);

    // Two-cycle latency on the first vector, then the rest back to back
    OUT_READY = 1'b1;
    send(vecs[0], 1'b0);
    IN_VALID = 1'b0;
    chk("latency_cycle1", {31'd0, OUT_VALID}, 32'd0);
    @(negedge CLK);
    chk("latency_cycle2", {31'd0, OUT_VALID}, 32'd1);
    for (int i = 1; i < 12; i++) send(vecs[i], 1'b0);
    IN_VALID = 1'b0;
    drain("table_drain");
    chk("table_enc_count", {16'd0, ENC_COUNT}, 32'd12);

    // Asynchronous reset mid-cycle with two requests in flight
    OUT_READY = 1'b0;
    send(vecs[0], 1'b0);
    send(vecs[6], 1'b0);
    IN_VALID = 1'b0;
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, OUT_VALID}, 32'd0);
    chk("arst_instruction", INSTRUCTION, 32'd0);
    chk("arst_imm_error", {31'd0, IMM_ERROR}, 32'd0);
    chk("arst_enc_count", {16'd0, ENC_COUNT}, 32'd0);
    sb_q.delete();
    @(negedge CLK);
    RST = 1'b0;
    OUT_READY = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge CLK);
      #1;
      if (OUT_VALID) seen++;
    end
    chk("arst_no_stale_word", 32'(seen), 32'd0);

    // Backpressure: four requests offered while the output is stalled
    OUT_READY = 1'b0;
    accepted = 0;
    fork
      begin
        send(vecs[2], 1'b0);
        send(vecs[5], 1'b0);
        send(vecs[9], 1'b0);
        send(vecs[7], 1'b0);
        IN_VALID = 1'b0;
      end
      begin
        repeat (5) @(negedge CLK);
        #3;
        chk("bp_accepts", 32'(accepted), 32'd2);
        chk("bp_in_ready_low", {31'd0, IN_READY}, 32'd0);
        chk("bp_out_valid", {31'd0, OUT_VALID}, 32'd1);
        chk("bp_first_word", INSTRUCTION, vecs[2].exp_instr);
        held = INSTRUCTION;
        repeat (3) @(negedge CLK);
        #3;
        chk("bp_word_held", INSTRUCTION, held);
        chk("bp_valid_held", {31'd0, OUT_VALID}, 32'd1);
        chk("bp_err_held", {31'd0, IMM_ERROR}, 32'd0);
        @(negedge CLK);
        OUT_READY = 1'b1;
      end
    join
    drain("bp_drain");
    chk("bp_enc_count", {16'd0, ENC_COUNT}, 32'd4);

    // Random legal round trip per immediate-bearing format, streamed at full rate
    OUT_READY = 1'b1;
    for (int f = 1; f <= 5; f++) begin
      for (int n = 0; n < 1000; n++) begin
        r = $urandom;
        v.fmt = 3'(f);
        case (f)
          1, 2:    v.imm = {{20{r[11]}}, r[11:0]};
          3:       v.imm = {r[31:12], 12'b0};
          4:       v.imm = {{19{r[12]}}, r[12:1], 1'b0};
          default: v.imm = {{11{r[20]}}, r[20:1], 1'b0};
        endcase
        v.op = 7'($urandom); v.rd = 5'($urandom); v.rs1 = 5'($urandom);
        v.rs2 = 5'($urandom); v.f3 = 3'($urandom); v.f7 = 7'($urandom);
        v.exp_instr = '0; v.exp_err = 1'b0;
        send(v, 1'b1);
      end
    end
    IN_VALID = 1'b0;
    drain("rand_drain");

    // Five erroneous requests after a reset
    do_reset();
    @(negedge CLK);
    send(vecs[1], 1'b0);
    send(vecs[4], 1'b0);
    send(vecs[7], 1'b0);
    send(vecs[8], 1'b0);
    send(vecs[11], 1'b0);
    IN_VALID = 1'b0;
    drain("err_drain");
    chk("err_enc_count", {16'd0, ENC_COUNT}, 32'd5);
`ifdef IMM_ENC_ERR_COUNT_EN
    chk("err_count", {16'd0, ERR_COUNT}, 32'd5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
